matrix_ram_arbiter: RTL and testbench
=====================================

# matrix_ram_arbiter

Round-robin arbiter and burst sequencer that shares the single read port of the matrix RAM among the four row processors. Each processor requests a burst (base address, word count). The arbiter grants one processor at a time, generates the RAM read addresses, and steers the returned data back to the owning lane with a per-lane valid. It sits between the processor-dispatch state machine's four processor lanes and the matrix RAM.

## Interface
Parameters:
- ADDR_W, 8, RAM address width
- DATA_W, 8, RAM data width
- LEN_W, 4, burst length field width (words)

Ports (reset is asynchronous, active-low; clock is clk):
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-low
- req_i  in  4  per-lane request, level; held high until that lane's done_o
- base_i  in  4*ADDR_W  packed per-lane burst base address; lane n at [n*ADDR_W +: ADDR_W]
- len_i  in  4*LEN_W  packed per-lane burst length in words; lane n at [n*LEN_W +: LEN_W]
- ram_rd_en_o  out  1  RAM read strobe
- ram_addr_o  out  ADDR_W  RAM read address
- ram_rdata_i  in  DATA_W  RAM read data, valid one cycle after ram_rd_en_o
- grant_o  out  4  one-hot owner of the RAM port; 0 when idle
- rd_data_o  out  DATA_W  registered copy of ram_rdata_i
- rd_valid_o  out  4  one-hot; lane n's rd_data_o is valid this cycle
- done_o  out  4  one-hot single-cycle pulse at burst end for the owning lane
- busy_o  out  1  high whenever state != IDLE

## Operation
- States: IDLE, BURST, DRAIN.
- Round-robin pointer rr_ptr (2 bits): lane with highest priority. Search order is rr_ptr, rr_ptr+1, ... mod 4.
- IDLE, with any req_i high at a clock edge:
  - Select the winner w by round-robin search.
  - Register grant_o = one-hot(w), latch base_i[w] and len_i[w], clear the word counter cnt.
  - If len = 0, go to DRAIN; otherwise go to BURST.
- IDLE, with req_i = 0: remain in IDLE; all outputs hold their reset values.
- BURST:
  - ram_rd_en_o = 1 and ram_addr_o = base + cnt every cycle; cnt increments.
  - Address addition is modulo 2^ADDR_W (wraps; no carry out).
  - After the read with cnt = len-1 is issued, go to DRAIN.
- DRAIN:
  - ram_rd_en_o = 0.
  - done_o = grant_o for this one cycle.
  - rr_ptr <= w+1 mod 4.
  - Next edge: grant_o <= 0, go to IDLE.
- Read return: rd_valid_o <= grant_o & {4{ram_rd_en_o}} and rd_data_o <= ram_rdata_i, both registered one cycle after each strobe. Because of this, the last data word's rd_valid_o coincides with the DRAIN cycle.
- Burst is non-preemptive:
  - req_i changes during BURST/DRAIN are ignored; a lane dropping req_i mid-burst still receives all words and done_o.
  - base_i/len_i changes after the grant are ignored.
- A lane whose req_i is still high after its done_o is treated as a new request. It competes at lowest priority because rr_ptr has moved past it.
- Reset, asynchronous and at any time including mid-burst:
  - State = IDLE, rr_ptr = 0, cnt = 0.
  - grant_o = 0, ram_rd_en_o = 0, ram_addr_o = 0, rd_data_o = 0, rd_valid_o = 0, done_o = 0, busy_o = 0.
  - An aborted burst produces no done_o.

## Timing
- Let the request be sampled high in IDLE at edge k, with length L >= 1:
  - grant_o and busy_o rise after edge k.
  - ram_rd_en_o is high in cycles k..k+L-1, addresses base..base+L-1.
  - rd_valid_o is high in cycles k+1..k+L.
  - done_o pulses in cycle k+L (DRAIN).
  - grant_o and busy_o fall after edge k+L+1.
- L = 0: grant in cycle k, done_o in cycle k+1, no RAM reads, no rd_valid_o.
- Minimum one IDLE cycle between consecutive bursts. Burst occupancy is L+2 cycles including that IDLE cycle.
- Maximum wait for a continuously requesting lane: 3 other bursts.
- Outputs are registered, except that busy_o may be decoded from state.

## Test plan
- Single request, lane 2, base 0x10, len 3 -> addresses 0x10, 0x11, 0x12 on consecutive cycles; rd_valid_o = 4'b0100 for 3 cycles carrying RAM[0x10..0x12]; done_o = 4'b0100 once; grant_o returns to 0.
- All four lanes request len 2 simultaneously from reset -> grants in order lane 0, 1, 2, 3; each gets exactly 2 valid words; rr_ptr ends at 0; no overlap of grant_o bits.
- Lane 1 base 0xFE, len 4 -> addresses 0xFE, 0xFF, 0x00, 0x01; done_o after 4 reads.
- Lane 3 len 0 -> grant_o = 4'b1000 for 2 cycles, done_o = 4'b1000 one cycle later, ram_rd_en_o never asserted.
- Lane 0 len 8; deassert req_i[0] after 2 reads while lane 1 requests -> lane 0 still receives all 8 words and done_o; lane 1 is granted next.
- Lane 2 len 6; assert reset after 3 reads -> all outputs 0 immediately; no done_o. After reset release with req_i[2] high, a fresh burst starts from base with rr_ptr = 0 priority.

Source files
------------

// File: rtl/matrix_ram_arbiter.sv
// Round-robin arbiter and burst sequencer sharing the matrix RAM read port
// among four row-processor lanes; returned data is steered back per lane.
module matrix_ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            req_i,
    input  logic [4*ADDR_W-1:0]   base_i,
    input  logic [4*LEN_W-1:0]    len_i,
    output logic                  ram_rd_en_o,
    output logic [ADDR_W-1:0]     ram_addr_o,
    input  logic [DATA_W-1:0]     ram_rdata_i,
    output logic [3:0]            grant_o,
    output logic [DATA_W-1:0]     rd_data_o,
    output logic [3:0]            rd_valid_o,
    output logic [3:0]            done_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t              state_q, state_d;
    logic [1:0]          rr_ptr_q, rr_ptr_d;
    logic [1:0]          owner_q, owner_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rd_en_q, rd_en_d;
    logic [3:0]          grant_q, grant_d;
    logic [3:0]          done_q, done_d;
    logic                zero_len_q, zero_len_d;
    logic [3:0]          rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q;

    logic                found;
    logic [1:0]          winner;
    logic [1:0]          idx;
    logic [ADDR_W-1:0]   base_sel;
    logic [LEN_W-1:0]    len_sel;
    logic [LEN_W-1:0]    cnt_inc;

    // Round-robin search starting at rr_ptr; first requesting lane wins.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr_q;
        idx    = rr_ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx    = rr_ptr_q + 2'(i);
            winner = (req_i[idx] && !found) ? idx : winner;
            found  = found | req_i[idx];
        end
        base_sel = base_i[winner*ADDR_W +: ADDR_W];
        len_sel  = len_i[winner*LEN_W +: LEN_W];
    end

    assign cnt_inc = cnt_q + LEN_ONE;

    // Next-state and registered-output decode for the burst sequencer.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        base_d     = base_q;
        zero_len_d = zero_len_q;
        grant_d    = grant_q;
        rd_en_d    = 1'b0;
        addr_d     = {ADDR_W{1'b0}};
        done_d     = 4'b0000;
        case (state_q)
            IDLE: begin
                if (found) begin
                    owner_d = winner;
                    grant_d = 4'b0001 << winner;
                    base_d  = base_sel;
                    len_d   = len_sel;
                    cnt_d   = {LEN_W{1'b0}};
                    if (len_sel == {LEN_W{1'b0}}) begin
                        state_d    = DRAIN;
                        zero_len_d = 1'b1;
                    end else begin
                        state_d    = BURST;
                        zero_len_d = 1'b0;
                        rd_en_d    = 1'b1;
                        addr_d     = base_sel;
                    end
                end else begin
                    grant_d = 4'b0000;
                end
            end
            BURST: begin
                if (cnt_q == (len_q - LEN_ONE)) begin
                    state_d = DRAIN;
                    done_d  = grant_q;
                end else begin
                    cnt_d   = cnt_inc;
                    rd_en_d = 1'b1;
                    addr_d  = base_q + ADDR_W'(cnt_inc);
                end
            end
            DRAIN: begin
                // A zero-length burst spends an extra DRAIN cycle so done_o
                // follows the grant instead of coinciding with it.
                if (zero_len_q) begin
                    zero_len_d = 1'b0;
                    done_d     = grant_q;
                end else begin
                    state_d  = IDLE;
                    grant_d  = 4'b0000;
                    rr_ptr_d = owner_q + 2'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                grant_d    = 4'b0000;
                zero_len_d = 1'b0;
            end
        endcase
    end

    // State, pointer and request-side output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 2'd0;
            owner_q    <= 2'd0;
            cnt_q      <= {LEN_W{1'b0}};
            len_q      <= {LEN_W{1'b0}};
            base_q     <= {ADDR_W{1'b0}};
            addr_q     <= {ADDR_W{1'b0}};
            rd_en_q    <= 1'b0;
            grant_q    <= 4'b0000;
            done_q     <= 4'b0000;
            zero_len_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            base_q     <= base_d;
            addr_q     <= addr_d;
            rd_en_q    <= rd_en_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            zero_len_q <= zero_len_d;
        end
    end

    // Read-return path: data and lane valid land one cycle after each strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid_q <= 4'b0000;
            rd_data_q  <= {DATA_W{1'b0}};
        end else begin
            rd_valid_q <= grant_q & {4{rd_en_q}};
            rd_data_q  <= rd_en_q ? ram_rdata_i : {DATA_W{1'b0}};
        end
    end

    assign ram_rd_en_o = rd_en_q;
    assign ram_addr_o  = addr_q;
    assign grant_o     = grant_q;
    assign done_o      = done_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_matrix_ram_arbiter.sv
// Scoreboard bench for matrix_ram_arbiter: expected reads, returned words and
// done pulses are queued at stimulus time and checked as the DUT produces them.
module tb_matrix_ram_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int LW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        req;
    logic [4*AW-1:0]   base;
    logic [4*LW-1:0]   len;
    logic              rd_en;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     rdata;
    logic [3:0]        grant, rd_valid, done;
    logic [DW-1:0]     rd_data;
    logic              busy;

    logic [DW-1:0]     mem [256];
    int vectors = 0;
    int miscompares = 0;

    logic [AW-1:0]     exp_addr_q [$];
    logic [DW+1:0]     exp_rd_q [$];
    int                exp_done_q [$];
    int                grant_seq [$];
    int                rem [4];
    int                t_grant [4];
    int                t_done [4];
    int                t_gfall [4];
    int                rd_cnt;

    logic [AW-1:0]     m_a;
    logic [DW+1:0]     m_rd;
    int                m_l;

    matrix_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset), .req_i(req), .base_i(base), .len_i(len),
        .ram_rd_en_o(rd_en), .ram_addr_o(addr), .ram_rdata_i(rdata),
        .grant_o(grant), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
        .done_o(done), .busy_o(busy)
    );

    always #5 clk = ~clk;
    assign rdata = mem[addr];

    // Scoreboard monitor: every strobe, returned word and done pulse is popped and compared.
    always @(negedge clk) begin
        if (reset) begin
            if (rd_en) begin
                vectors++;
                if (exp_addr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL ram_addr: unexpected read at %h, none expected", addr);
                end else begin
                    m_a = exp_addr_q.pop_front();
                    if (addr !== m_a) begin
                        miscompares++;
                        $display("FAIL ram_addr: got %h expected %h", addr, m_a);
                    end
                end
            end
            if (rd_valid !== 4'b0000) begin
                vectors++;
                if (exp_rd_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rd_valid: unexpected %b data %h", rd_valid, rd_data);
                end else begin
                    m_rd = exp_rd_q.pop_front();
                    if (rd_valid !== (4'b0001 << m_rd[DW+1:DW]) || rd_data !== m_rd[DW-1:0]) begin
                        miscompares++;
                        $display("FAIL rd_return: got valid %b data %h expected lane %0d data %h",
                                 rd_valid, rd_data, m_rd[DW+1:DW], m_rd[DW-1:0]);
                    end
                end
            end
            if (done !== 4'b0000) begin
                vectors++;
                if (exp_done_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL done: unexpected %b", done);
                end else begin
                    m_l = exp_done_q.pop_front();
                    if (done !== (4'b0001 << m_l)) begin
                        miscompares++;
                        $display("FAIL done: got %b expected lane %0d", done, m_l);
                    end
                end
            end
            if (grant !== 4'b0000) begin
                vectors++;
                if ((grant & (grant - 4'b0001)) !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL grant_onehot: got %b expected one-hot", grant);
                end
            end
        end
    end

    task automatic push_burst(input int lane, input logic [AW-1:0] b, input int l);
        logic [AW-1:0] a;
        base[lane*AW +: AW] = b;
        len[lane*LW +: LW]  = LW'(l);
        for (int i = 0; i < l; i++) begin
            a = b + AW'(i);
            exp_addr_q.push_back(a);
            exp_rd_q.push_back({2'(lane), mem[a]});
        end
        exp_done_q.push_back(lane);
    endtask

    task automatic flush_queues();
        exp_addr_q.delete();
        exp_rd_q.delete();
        exp_done_q.delete();
    endtask

    task automatic apply_reset();
        req = 4'b0000;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        flush_queues();
        @(negedge clk);
    endtask

    // Steps cycles, releasing each lane's request once it has seen rem[] done pulses.
    task automatic serve(input int budget);
        logic [3:0] prev = 4'b0000;
        int cyc = 0;
        bit finished = 1'b0;
        for (int n = 0; n < 4; n++) begin
            t_grant[n] = -1; t_done[n] = -1; t_gfall[n] = -1;
        end
        grant_seq.delete();
        rd_cnt = 0;
        while (!finished && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (rd_en) rd_cnt++;
            for (int n = 0; n < 4; n++) begin
                if (grant[n] && !prev[n]) begin
                    grant_seq.push_back(n);
                    if (t_grant[n] < 0) t_grant[n] = cyc;
                end
                if (!grant[n] && prev[n] && t_gfall[n] < 0) t_gfall[n] = cyc;
                if (done[n]) begin
                    if (t_done[n] < 0) t_done[n] = cyc;
                    rem[n]--;
                    if (rem[n] <= 0) req[n] = 1'b0;
                end
            end
            prev = grant;
            if (req == 4'b0000 && !busy && grant == 4'b0000) finished = 1'b1;
        end
        vectors++;
        if (!finished) begin
            miscompares++;
            $display("FAIL serve_timeout: still busy after %0d cycles, required idle", budget);
        end
    endtask

    task automatic test_reset();
        req = 4'b0000; base = '0; len = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        vectors += 3;
        if (grant !== 4'b0000) begin
            miscompares++; $display("FAIL reset_grant: got %b required 0000", grant);
        end
        if ({rd_en, addr} !== 9'h000) begin
            miscompares++; $display("FAIL reset_ram: got en %b addr %h required 0/00", rd_en, addr);
        end
        if ({rd_data, rd_valid, done, busy} !== 17'h00000) begin
            miscompares++;
            $display("FAIL reset_outputs: got data %h valid %b done %b busy %b required 0",
                     rd_data, rd_valid, done, busy);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({grant, rd_en, addr, rd_data, rd_valid, done, busy} !== 30'h0) begin
                miscompares++;
                $display("FAIL idle_hold: got grant %b en %b addr %h busy %b required all 0",
                         grant, rd_en, addr, busy);
            end
        end
    endtask

    task automatic test_single();
        push_burst(2, 8'h10, 3);
        rem[2] = 1;
        req = 4'b0100;
        serve(40);
        vectors += 5;
        if (t_grant[2] !== 1) begin
            miscompares++; $display("FAIL single_grant_cycle: got %0d required 1", t_grant[2]);
        end
        if (t_done[2] !== 4) begin
            miscompares++; $display("FAIL single_done_cycle: got %0d required 4", t_done[2]);
        end
        if (t_gfall[2] !== 5) begin
            miscompares++; $display("FAIL single_grant_fall: got %0d required 5", t_gfall[2]);
        end
        if (rd_cnt !== 3) begin
            miscompares++; $display("FAIL single_reads: got %0d required 3", rd_cnt);
        end
        if (exp_addr_q.size() + exp_rd_q.size() + exp_done_q.size() != 0) begin
            miscompares++;
            $display("FAIL single_drained: %0d events outstanding, required 0",
                     exp_addr_q.size() + exp_rd_q.size() + exp_done_q.size());
        end
    endtask

    task automatic test_all_four();
        int exp_seq [$];
        apply_reset();
        exp_seq = '{0, 1, 2, 3};
        for (int n = 0; n < 4; n++) begin
            push_burst(n, AW'(8'h20 * n), 2);
            rem[n] = 1;
        end
        req = 4'b1111;
        serve(100);
        vectors++;
        if (grant_seq.size() != 4) begin
            miscompares++; $display("FAIL rr_order_len: got %0d grants required 4", grant_seq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (grant_seq[i] != exp_seq[i]) begin
                    miscompares++;
                    $display("FAIL rr_order: slot %0d got lane %0d required %0d", i, grant_seq[i], exp_seq[i]);
                end
            end
        end
        vectors++;
        if (exp_rd_q.size() + exp_done_q.size() != 0) begin
            miscompares++; $display("FAIL all_four_drained: %0d outstanding required 0",
                                    exp_rd_q.size() + exp_done_q.size());
        end
        // Pointer back at 0: lane 0 beats lane 3.
        push_burst(0, 8'h00, 0);
        push_burst(3, 8'h00, 0);
        rem[0] = 1; rem[3] = 1;
        req = 4'b1001;
        serve(40);
        vectors++;
        if (grant_seq.size() == 0 || grant_seq[0] != 0) begin
            miscompares++;
            $display("FAIL rr_ptr_wrap: first grant lane %0d required 0",
                     (grant_seq.size() == 0) ? -1 : grant_seq[0]);
        end
    endtask

    task automatic test_wrap();
        push_burst(1, 8'hFE, 4);
        rem[1] = 1;
        req = 4'b0010;
        serve(40);
        vectors += 2;
        if (t_done[1] !== 5) begin
            miscompares++; $display("FAIL wrap_done_cycle: got %0d required 5", t_done[1]);
        end
        if (exp_addr_q.size() + exp_rd_q.size() + exp_done_q.size() != 0) begin
            miscompares++; $display("FAIL wrap_drained: outstanding %0d required 0",
                                    exp_addr_q.size() + exp_rd_q.size() + exp_done_q.size());
        end
    endtask

    task automatic test_len_zero();
        push_burst(3, 8'h44, 0);
        rem[3] = 1;
        req = 4'b1000;
        serve(40);
        vectors += 4;
        if (t_grant[3] !== 1) begin
            miscompares++; $display("FAIL len0_grant_cycle: got %0d required 1", t_grant[3]);
        end
        if (t_done[3] !== 2) begin
            miscompares++; $display("FAIL len0_done_cycle: got %0d required 2", t_done[3]);
        end
        if (t_gfall[3] !== 3) begin
            miscompares++; $display("FAIL len0_grant_fall: got %0d required 3", t_gfall[3]);
        end
        if (rd_cnt !== 0) begin
            miscompares++; $display("FAIL len0_reads: got %0d required 0", rd_cnt);
        end
    endtask

    task automatic test_no_preempt();
        apply_reset();
        push_burst(0, 8'h40, 8);
        push_burst(1, 8'h80, 2);
        req = 4'b0011;
        repeat (2) @(negedge clk);
        req[0] = 1'b0;
        rem[0] = 1; rem[1] = 1;
        serve(100);
        vectors += 2;
        if (grant_seq.size() != 2 || grant_seq[0] != 0 || grant_seq[1] != 1) begin
            miscompares++;
            $display("FAIL no_preempt_order: got %0d grants first %0d required lanes 0 then 1",
                     grant_seq.size(), (grant_seq.size() == 0) ? -1 : grant_seq[0]);
        end
        if (exp_addr_q.size() + exp_rd_q.size() + exp_done_q.size() != 0) begin
            miscompares++; $display("FAIL no_preempt_drained: outstanding %0d required 0",
                                    exp_addr_q.size() + exp_rd_q.size() + exp_done_q.size());
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        push_burst(0, 8'h30, 1);
        push_burst(1, 8'h31, 1);
        push_burst(0, 8'h30, 1);
        rem[0] = 2; rem[1] = 1;
        req = 4'b0011;
        serve(100);
        vectors += 3;
        if (grant_seq.size() != 3 || grant_seq[0] != 0 || grant_seq[1] != 1 || grant_seq[2] != 0) begin
            miscompares++;
            $display("FAIL b2b_order: got %0d grants required lanes 0,1,0", grant_seq.size());
        end
        if (t_grant[1] !== 4) begin
            miscompares++; $display("FAIL b2b_idle_gap: lane1 grant cycle %0d required 4", t_grant[1]);
        end
        if (exp_rd_q.size() + exp_done_q.size() != 0) begin
            miscompares++; $display("FAIL b2b_drained: outstanding %0d required 0",
                                    exp_rd_q.size() + exp_done_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int reads = 0;
        int guard = 0;
        apply_reset();
        push_burst(1, 8'h00, 0);
        rem[1] = 1;
        req = 4'b0010;
        serve(40);
        push_burst(2, 8'h50, 6);
        req = 4'b0100;
        while (reads < 3 && guard < 20) begin
            @(negedge clk);
            guard++;
            if (rd_en) reads++;
        end
        vectors++;
        if (reads < 3) begin
            miscompares++; $display("FAIL abort_setup: got %0d reads required 3", reads);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({grant, rd_en, addr, rd_data, rd_valid, done, busy} !== 30'h0) begin
            miscompares++;
            $display("FAIL abort_outputs: got grant %b en %b addr %h valid %b done %b busy %b required 0",
                     grant, rd_en, addr, rd_valid, done, busy);
        end
        flush_queues();
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (done !== 4'b0000) begin
                miscompares++; $display("FAIL abort_done: got %b required 0000", done);
            end
        end
        push_burst(1, 8'h60, 2);
        push_burst(2, 8'h50, 6);
        rem[1] = 1; rem[2] = 1;
        req = 4'b0110;
        reset = 1'b1;
        serve(100);
        vectors += 2;
        if (grant_seq.size() != 2 || grant_seq[0] != 1 || grant_seq[1] != 2) begin
            miscompares++;
            $display("FAIL abort_rr_reset: got %0d grants first %0d required lanes 1 then 2",
                     grant_seq.size(), (grant_seq.size() == 0) ? -1 : grant_seq[0]);
        end
        if (exp_addr_q.size() + exp_rd_q.size() + exp_done_q.size() != 0) begin
            miscompares++; $display("FAIL abort_fresh_drained: outstanding %0d required 0",
                                    exp_addr_q.size() + exp_rd_q.size() + exp_done_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3) ^ 8'hA5;
        test_reset();
        test_single();
        test_all_four();
        test_wrap();
        test_len_zero();
        test_no_preempt();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
